// File: rtl/tx_pkg.sv
// Shared types and line levels for the framed serial transmitter.
package tx_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, shift-right register exposing its LSB; load wins over shift.
module piso_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             lsb
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= din;
    end else if (shift) begin
      data_q <= {1'b0, data_q[WIDTH-1:1]};
    end
  end

  assign lsb = data_q[0];

endmodule

// File: rtl/piso_frame_tx.sv
// Framed PISO transmitter: start bit, WIDTH data bits LSB first, stop bit, paced by en.
import tx_pkg::*;

module piso_frame_tx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_out_n,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  tx_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ser_q, ser_n_q, busy_q, done_q;
  logic             accept, shift, lsb, ser_d;

  assign load_ready = (state_q == IDLE);
  assign accept     = load_valid && load_ready;

  // The register runs one bit ahead of the line: it shifts as each bit is
  // latched into ser_q, so lsb is always the next bit to send.
  always_comb begin
    shift = en && ((state_q == START) || ((state_q == DATA) && (cnt_q != LAST)));
    ser_d = ser_q;
    unique case (state_q)
      IDLE:  ser_d = accept ? START_BIT : IDLE_LEVEL;
      START: if (en) ser_d = lsb;
      DATA:  if (en) ser_d = (cnt_q == LAST) ? STOP_BIT : lsb;
      STOP:  if (en) ser_d = IDLE_LEVEL;
      default: ser_d = IDLE_LEVEL;
    endcase
  end

  piso_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk  (clk),
    .reset(reset),
    .load (accept),
    .shift(shift),
    .din  (load_data),
    .lsb  (lsb)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ser_q   <= IDLE_LEVEL;
      ser_n_q <= ~IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ser_q   <= ser_d;
      ser_n_q <= ~ser_d;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (en) state_q <= DATA;
        end
        DATA: begin
          if (en) begin
            if (cnt_q == LAST) state_q <= STOP;
            else               cnt_q   <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (en) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ser_out   = ser_q;
  assign ser_out_n = ser_n_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_piso_frame_tx.sv
// Scoreboard bench for piso_frame_tx: expected line bits queued at accept, checked per cycle.
module tb_piso_frame_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b1;
  logic       lv8 = 1'b0;
  logic [7:0] ld8 = '0;
  logic       ready8, ser8, ser_n8, busy8, done8;
  logic       lv2 = 1'b0;
  logic [1:0] ld2 = '0;
  logic       ready2, ser2, ser_n2, busy2, done2;

  logic inv_ser8, inv_busy8, inv_ser2, inv_busy2;
  assign inv_ser8  = ~ser8;
  assign inv_busy8 = ~busy8;
  assign inv_ser2  = ~ser2;
  assign inv_busy2 = ~busy2;

  int n_checks = 0;
  int n_fail = 0;
  int en_period = 1;
  int phase = 0;
  int done8_cnt = 0;
  int done2_cnt = 0;
  int busy8_cycles = 0;
  int busy2_cycles = 0;
  logic exp8_q[$];
  logic exp2_q[$];

  piso_frame_tx #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .load_valid(lv8),
    .load_data (ld8),
    .load_ready(ready8),
    .ser_out   (ser8),
    .ser_out_n (ser_n8),
    .busy      (busy8),
    .done      (done8)
  );

  piso_frame_tx #(.WIDTH(2)) u_dut2 (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .load_valid(lv2),
    .load_data (ld2),
    .load_ready(ready2),
    .ser_out   (ser2),
    .ser_out_n (ser_n2),
    .busy      (busy2),
    .done      (done2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // en is high for the edge that follows every en_period-th cycle
  always @(posedge clk) begin
    #1;
    phase = (phase + 1) % en_period;
    en = (phase == 0);
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("ser_n8", ser_n8, inv_ser8);
      check("ready8", ready8, inv_busy8);
      if (busy8) begin
        busy8_cycles++;
        check("q8_nonempty", exp8_q.size() != 0, 1);
        if (exp8_q.size() != 0) begin
          check("bit8", ser8, exp8_q[0]);
          if (en) void'(exp8_q.pop_front());
        end
      end else begin
        check("idle8", ser8, 1);
      end
      if (done8) begin
        done8_cnt++;
        check("done8_q_empty", exp8_q.size(), 0);
      end
      check("ser_n2", ser_n2, inv_ser2);
      check("ready2", ready2, inv_busy2);
      if (busy2) begin
        busy2_cycles++;
        check("q2_nonempty", exp2_q.size() != 0, 1);
        if (exp2_q.size() != 0) begin
          check("bit2", ser2, exp2_q[0]);
          if (en) void'(exp2_q.pop_front());
        end
      end else begin
        check("idle2", ser2, 1);
      end
      if (done2) begin
        done2_cnt++;
        check("done2_q_empty", exp2_q.size(), 0);
      end
    end
  end

  task automatic push_frame8(input logic [7:0] d);
    exp8_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp8_q.push_back(d[i]);
    exp8_q.push_back(1'b1);
    busy8_cycles = 0;
  endtask

  task automatic send8(input logic [7:0] d, input bit align, input bit hold);
    int t = 0;
    do begin
      @(posedge clk);
      #2;
      t++;
    end while (!(ready8 && (!align || en)) && t < 500);
    check("ready_wait8", ready8, 1);
    lv8 = 1'b1;
    ld8 = d;
    @(posedge clk);
    push_frame8(d);
    #1;
    if (!hold) lv8 = 1'b0;
  endtask

  // Returns at posedge+2 inside the done cycle, before the edge that ends it
  task automatic wait_done8();
    int t = 0;
    do begin
      @(posedge clk);
      #2;
      t++;
    end while (!done8 && t < 500);
    check("done_wait8", done8, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #12;
    check("rst_ser", ser8, 1);
    check("rst_ser_n", ser_n8, 0);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_ready", ready8, 1);
    @(posedge clk);
    #2;
    reset = 1'b0;

    // Basic frame
    send8(8'hA5, 1'b0, 1'b0);
    wait_done8();
    check("len_a5", busy8_cycles, 10);

    // en every 4th cycle, accept aligned to a tick
    en_period = 4;
    send8(8'h3C, 1'b1, 1'b0);
    wait_done8();
    check("len_3c", busy8_cycles, 40);
    en_period = 1;

    // Loads while busy are ignored
    send8(8'hFF, 1'b0, 1'b1);
    ld8 = 8'h00;
    wait_done8();
    lv8 = 1'b0;
    check("len_ff", busy8_cycles, 10);

    // Back-to-back: second word captured in the done cycle
    send8(8'h01, 1'b0, 1'b1);
    wait_done8();
    ld8 = 8'h80;
    @(posedge clk);
    push_frame8(8'h80);
    #1;
    lv8 = 1'b0;
    #2;
    check("b2b_busy", busy8, 1);
    wait_done8();
    check("len_80", busy8_cycles, 10);

    // Reset during data bit 3
    send8(8'h5A, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_ser", ser8, 1);
    check("mid_rst_ser_n", ser_n8, 0);
    check("mid_rst_busy", busy8, 0);
    check("mid_rst_ready", ready8, 1);
    check("mid_rst_done", done8, 0);
    exp8_q.delete();
    @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    #1;
    check("done8_total", done8_cnt, 5);

    // WIDTH=2 instance
    @(posedge clk);
    #2;
    check("ready2_idle", ready2, 1);
    lv2 = 1'b1;
    ld2 = 2'b10;
    @(posedge clk);
    exp2_q.push_back(1'b0);
    exp2_q.push_back(1'b0);
    exp2_q.push_back(1'b1);
    exp2_q.push_back(1'b1);
    busy2_cycles = 0;
    #1;
    lv2 = 1'b0;
    for (int t = 0; t < 20 && !done2; t++) begin
      @(posedge clk);
      #2;
    end
    check("done_wait2", done2, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("len_w2", busy2_cycles, 4);
    check("done2_total", done2_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_frame_tx.md
Name: piso_frame_tx

Overview:
- Parallel-in, serial-out framed transmitter: it is the transmit end for the lab's serial-in chain of master-slave D flip-flops.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out on one line as a frame: start bit (0), WIDTH data bits LSB first, stop bit (1).
- Shared `en` acts as a bit-rate tick. It lets the receiver-side flip-flop chain and this block run from the same `clk`/`en`.

Parameters:
- WIDTH, 8, data bits per frame (legal range 2..32).
- CNT_W, $clog2(WIDTH), bit-counter width (derived; not overridden).

Ports:
- clk         input   1          rising-edge clock
- reset       input   1          asynchronous, active-high reset
- en          input   1          bit tick; state advances only on edges where en=1 (load acceptance excepted)
- load_valid  input   1          load_data is valid
- load_data   input   WIDTH      word to transmit
- load_ready  output  1          block can accept a word (combinational: state==IDLE)
- ser_out     output  1          serial line (Q); idles high
- ser_out_n   output  1          complement of ser_out (Qn), always exactly ~ser_out
- busy        output  1          frame in progress (state!=IDLE)
- done        output  1          one-cycle pulse after stop bit completes

Behaviour:
- Reset (asynchronous, active-high; applies at once, including mid-frame):
  - state=IDLE, ser_out=1, ser_out_n=0, busy=0, done=0, shift register=0, bit counter=0.
  - load_ready=1 while in reset.
  - A frame interrupted by reset is abandoned and not resumed.
- States: IDLE, START, DATA, STOP. All outputs except load_ready are registered.
- IDLE:
  - ser_out=1.
  - On an edge with load_valid && load_ready: capture load_data into the shift register, clear the counter, go to START. This happens regardless of en.
  - load_valid with WIDTH bits undefined is not checked.
- START:
  - ser_out=0.
  - On an edge with en=1: go to DATA, ser_out=shift[0].
- DATA:
  - ser_out=current LSB.
  - On each edge with en=1: if counter==WIDTH-1, go to STOP (ser_out=1); otherwise shift right by one, counter+1, and drive the new LSB.
- STOP:
  - ser_out=1.
  - On an edge with en=1: go to IDLE and set done=1 for exactly one cycle.
- en=0 in START/DATA/STOP: all state, counter, shift register and ser_out hold. Bit period = interval between en-high edges.
- load_valid while busy: ignored (load_ready=0). load_data is not sampled and does not corrupt the frame.
- Latency with en tied high:
  - Accept edge T0.
  - Start bit during cycle T0+1.
  - Data bits during T0+2..T0+WIDTH+1.
  - Stop bit during T0+WIDTH+2.
  - done=1 and load_ready=1 during T0+WIDTH+3.
  - Frame = WIDTH+2 bit periods. The earliest next accept is at the edge that ends cycle T0+WIDTH+3.
- done and a new accept may coincide: done pulses while the new word is captured.
- Counter never exceeds WIDTH-1 (no wrap-around).

Decomposition:
- Shared package `tx_pkg`:
  - enum `tx_state_t` {IDLE, START, DATA, STOP}.
  - Constants `START_BIT`=0, `STOP_BIT`=1, `IDLE_LEVEL`=1.
- One natural sub-module, `piso_shift_reg`:
  - Ports: clk, reset, load, shift, din[WIDTH], lsb.
  - Asynchronous active-high reset; load has priority over shift.
- Top-level `piso_frame_tx` holds the FSM, bit counter, ser_out/ser_out_n/done registers, and the handshake.

Test Plan:
- Reset mid-frame: assert reset during data bit 3 -> same-cycle ser_out=1, ser_out_n=0, busy=0, load_ready=1. After release, no residual bits are transmitted.
- Basic frame, WIDTH=8, en=1, load 8'hA5 -> ser_out sequence over 10 cycles is 0,1,0,1,0,0,1,0,1,1. done pulses once in cycle 11; ser_out_n is the complement throughout.
- Tick gating: en high every 4th cycle, load 8'h3C -> each bit is held exactly 4 cycles. Sequence is 0,0,0,1,1,1,1,0,0,1, and frame length is 40 cycles.
- Busy rejection: load 8'hFF, then hold load_valid=1 with 8'h00 during the frame -> load_ready=0 throughout, and the transmitted data bits are all 1.
- Back-to-back: load_valid held high with 8'h01, then 8'h80 at done -> the second frame starts with no extra idle beyond the single IDLE cycle. Data bits are 1,0,0,0,0,0,0,0, then 0,0,0,0,0,0,0,1.
- WIDTH=2 instance, load 2'b10 -> line 0,0,1,1; counter stops at 1 and done pulses once.
